// File: rtl/jtkcpu_pshpul.sv
// jtkcpu_pshpul -- PSHS/PSHU/PULS/PULU stack sequencer.
// Walks a postbyte register mask one byte per DEC/WR (push) or RD/LD (pull)
// state pair. It drives the register file selector and the memory strobes.
// One state per cen cycle. All outputs decode from registered state, so they
// stay frozen while cen=0.
module jtkcpu_pshpul (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       start_psh,
    input  logic       start_pul,
    input  logic [7:0] postbyte,
    input  logic       ussel,
    input  logic [7:0] psh_mux,
    output logic [7:0] psh_sel,
    output logic       psh_hilon,
    output logic       psh_ussel,
    output logic       pshdec,
    output logic       pul_en,
    output logic       mem_we,
    output logic       mem_rd,
    output logic [7:0] mem_dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        LD   = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t     st, st_nx;
    logic [7:0] mask, mask_nx;   // registers still to be transferred
    logic       half, half_nx;   // first byte of a 16-bit register already moved
    logic       pull, pull_nx;   // latched direction of the running sequence
    logic       us_nx;

    logic [7:0] hi_bit;          // one-hot of highest pending bit (push order)
    logic [7:0] lo_bit;          // one-hot of lowest pending bit (pull order)
    logic [7:0] cur;             // register being transferred now
    logic [7:0] rest;            // mask once the current register retires
    logic       is16;            // X, Y, U/S and PC take two bytes
    logic       last;            // current byte completes its register

    // Highest-set-bit priority encoder; later iterations win.
    always_comb begin
        hi_bit = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) hi_bit = 8'h01 << i;
        end
    end

    assign lo_bit = mask & (~mask + 8'h01);
    assign cur    = pull ? lo_bit : hi_bit;
    assign rest   = mask & ~cur;
    assign is16   = |(cur & 8'hF0);
    assign last   = ~is16 | half;

    // State, mask, half flag, direction and stack select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            mask      <= 8'h00;
            half      <= 1'b0;
            pull      <= 1'b0;
            psh_ussel <= 1'b0;
        end else if (cen) begin
            st        <= st_nx;
            mask      <= mask_nx;
            half      <= half_nx;
            pull      <= pull_nx;
            psh_ussel <= us_nx;
        end
    end

    // Next-state logic. Starts are only looked at in IDLE, and the postbyte
    // matters only on the start cycle.
    always_comb begin
        st_nx   = st;
        mask_nx = mask;
        half_nx = half;
        pull_nx = pull;
        us_nx   = psh_ussel;
        case (st)
            IDLE: begin
                if (start_psh || start_pul) begin
                    mask_nx = postbyte;
                    us_nx   = ussel;
                    pull_nx = ~start_psh;      // push has priority
                    half_nx = 1'b0;
                    if (postbyte == 8'h00) st_nx = FIN;
                    else                   st_nx = start_psh ? DEC : RD;
                end
            end
            DEC: st_nx = WR;
            RD:  st_nx = LD;
            WR, LD: begin
                if (last) begin
                    mask_nx = rest;
                    half_nx = 1'b0;
                    if (rest == 8'h00) st_nx = FIN;
                    else               st_nx = (st == WR) ? DEC : RD;
                end else begin
                    half_nx = 1'b1;
                    st_nx   = (st == WR) ? DEC : RD;
                end
            end
            FIN:     st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    // Output decode. Push selects the single register being stored. Pull
    // hands over the whole mask, and the register file picks the lowest bit.
    always_comb begin
        psh_sel   = 8'h00;
        psh_hilon = 1'b0;
        pshdec    = 1'b0;
        pul_en    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        busy      = (st != IDLE);
        done      = (st == FIN);
        case (st)
            DEC, WR: begin
                psh_sel   = hi_bit;
                psh_hilon = is16 & half;    // low byte goes first (higher address)
                pshdec    = (st == DEC);
                mem_we    = (st == WR);
            end
            RD, LD: begin
                psh_sel   = mask;
                psh_hilon = is16 & ~half;   // high byte comes back first
                mem_rd    = (st == RD);
                pul_en    = (st == LD);
            end
            default: ;
        endcase
    end

    assign mem_dout = psh_mux;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Directed bench for jtkcpu_pshpul. Inputs change 1 ns after posedge clk,
// and outputs are sampled at that same point.
module tb_jtkcpu_pshpul;

    logic       rst, clk, cen;
    logic       start_psh, start_pul, ussel;
    logic [7:0] postbyte, psh_mux;
    logic [7:0] psh_sel, mem_dout;
    logic       psh_hilon, psh_ussel, pshdec, pul_en, mem_we, mem_rd, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    jtkcpu_pshpul dut (
        .rst(rst), .clk(clk), .cen(cen),
        .start_psh(start_psh), .start_pul(start_pul),
        .postbyte(postbyte), .ussel(ussel), .psh_mux(psh_mux),
        .psh_sel(psh_sel), .psh_hilon(psh_hilon), .psh_ussel(psh_ussel),
        .pshdec(pshdec), .pul_en(pul_en), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {sel, hilon, ussel, pshdec, pul_en, we, rd, busy, done}
    function automatic logic [15:0] outs();
        return {psh_sel, psh_hilon, psh_ussel, pshdec, pul_en, mem_we, mem_rd, busy, done};
    endfunction

    // expected {sel, hilon, pshdec, pul_en, we, rd, busy, done}
    task automatic chk_st(input string tag, input logic [7:0] sel, input logic hl,
                          input logic [3:0] strb, input logic bz, input logic dn);
        chk(tag, {psh_sel, psh_hilon, pshdec, pul_en, mem_we, mem_rd, busy, done},
                 {sel, hl, strb, bz, dn});
    endtask

    task automatic start(input logic p, input logic u, input logic [7:0] pb, input logic us);
        start_psh = p; start_pul = u; postbyte = pb; ussel = us;
        step();
        start_psh = 0; start_pul = 0;
    endtask

    // strobe field order: pshdec, pul_en, we, rd
    localparam logic [3:0] S_DEC = 4'b1000, S_LD = 4'b0100, S_WR = 4'b0010,
                           S_RD = 4'b0001, S_NO = 4'b0000;

    int cnt;
    logic [15:0] snap;

    initial begin
        rst = 1; cen = 1; start_psh = 0; start_pul = 0; ussel = 0;
        postbyte = 0; psh_mux = 8'hA5;
        #1;
        chk_st("reset_outs", 8'h00, 0, S_NO, 0, 0);
        chk("reset_ussel", psh_ussel, 0);
        step(); step();
        rst = 0;

        // push CC only
        start(1, 0, 8'h01, 0);
        chk_st("p01_dec", 8'h01, 0, S_DEC, 1, 0);
        step();
        chk_st("p01_wr", 8'h01, 0, S_WR, 1, 0);
        chk("p01_dout", mem_dout, 8'hA5);
        step();
        chk_st("p01_fin", 8'h00, 0, S_NO, 1, 1);
        step();
        chk_st("p01_idle", 8'h00, 0, S_NO, 0, 0);

        // push PC; postbyte changed after start must not matter
        start(1, 0, 8'h80, 0);
        postbyte = 8'hFF;
        chk_st("p80_dec0", 8'h80, 0, S_DEC, 1, 0); step();
        chk_st("p80_wr0",  8'h80, 0, S_WR,  1, 0); step();
        chk_st("p80_dec1", 8'h80, 1, S_DEC, 1, 0); step();
        chk_st("p80_wr1",  8'h80, 1, S_WR,  1, 0); step();
        chk_st("p80_fin",  8'h00, 0, S_NO,  1, 1); step();
        chk_st("p80_idle", 8'h00, 0, S_NO,  0, 0);

        // pull X then PC on U stack: lowest bit first, high byte first
        start(0, 1, 8'h90, 1);
        chk("p90_ussel", psh_ussel, 1);
        chk_st("p90_rd0", 8'h90, 1, S_RD, 1, 0); step();
        chk_st("p90_ld0", 8'h90, 1, S_LD, 1, 0); step();
        chk_st("p90_rd1", 8'h90, 0, S_RD, 1, 0); step();
        chk_st("p90_ld1", 8'h90, 0, S_LD, 1, 0); step();
        chk_st("p90_rd2", 8'h80, 1, S_RD, 1, 0); step();
        chk_st("p90_ld2", 8'h80, 1, S_LD, 1, 0); step();
        chk_st("p90_rd3", 8'h80, 0, S_RD, 1, 0); step();
        chk_st("p90_ld3", 8'h80, 0, S_LD, 1, 0); step();
        chk_st("p90_fin", 8'h00, 0, S_NO, 1, 1); step();
        chk_st("p90_idle", 8'h00, 0, S_NO, 0, 0);

        // empty mask
        start(1, 0, 8'h00, 0);
        chk_st("p00_fin", 8'h00, 0, S_NO, 1, 1); step();
        chk_st("p00_idle", 8'h00, 0, S_NO, 0, 0);

        // both starts: push wins; starts while busy ignored
        start(1, 1, 8'h02, 0);
        chk_st("both_dec", 8'h02, 0, S_DEC, 1, 0);
        start_pul = 1; start_psh = 1; postbyte = 8'hFF;
        cnt = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (mem_we) cnt++;
            chk("both_no_rd", mem_rd, 0);
            step();
        end
        start_pul = 0; start_psh = 0;
        chk("both_we_cnt", cnt, 1);
        chk("both_done", done, 1);
        step();
        chk_st("both_idle", 8'h00, 0, S_NO, 0, 0);

        // reset during push of FF at byte 5 (first byte of Y)
        start(1, 0, 8'hFF, 1);
        for (int i = 0; i < 8; i++) step();
        chk_st("rst_pre", 8'h20, 0, S_DEC, 1, 0);
        #2 rst = 1;
        #1;
        chk_st("rst_async", 8'h00, 0, S_NO, 0, 0);
        chk("rst_ussel", psh_ussel, 0);
        step();
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) cnt++;
            step();
        end
        chk("rst_no_done", cnt, 0);
        start(1, 0, 8'h01, 0);
        step(); step();
        chk("rst_after_done", done, 1);
        step();

        // cen toggling during pull of A,B
        cnt = 0;
        start(0, 1, 8'h06, 0);
        cnt++;
        chk_st("cen_rd0", 8'h06, 0, S_RD, 1, 0);
        for (int i = 0; i < 12 && !done; i++) begin
            cen = 0;
            snap = outs();
            step();
            chk("cen_frozen", outs(), snap);
            cen = 1;
            step();
            cnt++;
        end
        chk("cen_count", cnt, 5);
        chk_st("cen_fin", 8'h00, 0, S_NO, 1, 1);
        cen = 0; step();
        chk("cen_done_hold", done, 1);
        cen = 1; step();
        chk_st("cen_idle", 8'h00, 0, S_NO, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
